frame_mem_arb: RTL and testbench
================================

# frame_mem_arb

Arbiter for the single-port frame memory shared by the camera capture path (writer) and the VGA scan-out path (reader). VGA reads have strict priority so scan-out never misses a pixel. Camera writes are buffered in a small FIFO and drained into memory on cycles with no read. The block sits between `camera_ctrl` and `vga_ctrl` in the `qu_clk` domain, and it owns all memory command signals.

## Interface
Parameters:
- `ADDR_W`, 17, frame memory address width
- `DATA_W`, 9, pixel width (RGB 3:3:3)
- `FIFO_DEPTH`, 4, write FIFO entries; must be a power of two, ≥2

Ports:
- `clk`  in  1  memory/arbiter clock (one clock; the only clock)
- `rst`  in  1  asynchronous, active-high reset
- `vga_req`  in  1  read request, one pixel per cycle
- `vga_addr`  in  ADDR_W  read address
- `vga_q`  out  DATA_W  read data
- `vga_valid`  out  1  `vga_q` valid this cycle
- `cam_wr`  in  1  write strobe
- `cam_addr`  in  ADDR_W  write address
- `cam_data`  in  DATA_W  write data
- `cam_flush`  in  1  synchronous FIFO discard (pulse on frame start)
- `cam_full`  out  1  FIFO holds FIFO_DEPTH entries
- `overflow`  out  1  sticky: write dropped
- `mem_en`, `mem_we`  out  1 each  memory command
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, one cycle after read command
- `stall_cnt`, `drop_cnt`  out  16 each  statistics (see Configuration)

## Operation
- Command register states: IDLE (`mem_en`=0), RD (`mem_en`=1, `mem_we`=0), WR (`mem_en`=1, `mem_we`=1). One state is chosen at every edge from the inputs and FIFO state sampled at that edge.
- Selection priority: `vga_req` → RD with `vga_addr`. Else FIFO non-empty and not flushing → WR with the FIFO head, and the head is popped. Else → IDLE.
- FIFO push: `cam_wr` && !`cam_full` stores {`cam_addr`,`cam_data`}. A push and a pop in the same cycle leave the count unchanged. `cam_wr` while `cam_full` is high drops the write, even if a pop occurs that cycle, and sets `overflow`. `overflow` is cleared only by `rst`.
- `cam_flush`: empties the FIFO at the edge. A concurrent `cam_wr` in the same cycle is kept as the sole entry. No WR is issued from the discarded contents.
- Read return: a flag pipelined with RD qualifies `mem_rdata`, which is registered into `vga_q` with `vga_valid`=1.
- Pointers wrap modulo FIFO_DEPTH. The count is 0..FIFO_DEPTH. `cam_full` = (count == FIFO_DEPTH), registered.
- Reset values: every output is 0, FIFO is empty, state is IDLE. Reset asserted mid-operation aborts any in-flight write or read. No `vga_valid` is produced for reads already in the pipeline.

## Timing
- Read latency: `vga_req` in cycle t → RD command in t+1 → `mem_rdata` in t+2 → `vga_q`/`vga_valid` in t+3. Fixed at 3 cycles, fully pipelined, one read per cycle.
- Write: `cam_wr` in cycle t into an empty FIFO with no `vga_req` in t+1 → WR command in t+2. Any cycle with `vga_req` defers the write by one cycle per request.
- `cam_full` reflects the count after the edge. It is not a same-cycle combinational ready.
- Continuous `vga_req` starves writes indefinitely. Drain relies on blanking intervals.

## Configuration
- `FRAME_ARB_STATS_EN` defined:
  - `stall_cnt` increments on every cycle where the FIFO is non-empty and `vga_req` blocks a write.
  - `drop_cnt` increments on every dropped write.
  - Both counters are 16-bit, saturate at 0xFFFF, and are cleared by `rst` and by `cam_flush`.
- Not defined: both ports are driven constant 0, and no counter logic is built.

## Test plan
- Reset, then idle 5 cycles → `mem_en`=0, `vga_valid`=0, `cam_full`=0, `overflow`=0.
- `vga_req` with addr 0x00010 while memory holds 0x1A5 there → RD command at t+1; `vga_q`=0x1A5 and `vga_valid`=1 exactly at t+3. A back-to-back burst of 8 addresses returns 8 consecutive valid cycles.
- `cam_wr` addr 0x00020 data 0x0F0 with `vga_req` held high for 6 cycles → no WR until `vga_req` drops, then a single WR to 0x00020 with data 0x0F0. With stats on, `stall_cnt`=6 (or 5 if `vga_req` overlaps only 5 of the FIFO-non-empty cycles).
- 6 consecutive `cam_wr` with FIFO_DEPTH=4 under continuous `vga_req` → `cam_full`=1 after the 4th write, writes 5–6 dropped, `overflow`=1, `drop_cnt`=2. Releasing `vga_req` yields exactly 4 WRs in order.
- FIFO holds 3 entries; `cam_flush` together with `cam_wr` (addr 0x00030) → only 0x00030 is written.
- Assert `rst` one cycle after a RD command → no `vga_valid` appears, all outputs are 0 asynchronously, and normal operation resumes after release.

Source files
------------

// File: rtl/frame_mem_arb_if.sv
// Frame memory arbiter bus bundle: VGA read port, camera write port,
// memory command/return signals and statistics outputs.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever surrounds it (capture path, scan-out path, memory).
interface frame_mem_arb_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 9
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_q;
    logic              vga_valid;

    logic              cam_wr;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;
    logic              cam_flush;
    logic              cam_full;
    logic              overflow;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [15:0]       stall_cnt;
    logic [15:0]       drop_cnt;

    modport slave (
        input  vga_req, vga_addr, cam_wr, cam_addr, cam_data, cam_flush, mem_rdata,
        output vga_q, vga_valid, cam_full, overflow,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_cnt, drop_cnt
    );

    modport master (
        output vga_req, vga_addr, cam_wr, cam_addr, cam_data, cam_flush, mem_rdata,
        input  vga_q, vga_valid, cam_full, overflow,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_cnt, drop_cnt
    );
endinterface

// File: rtl/frame_mem_arb.sv
// Single-port frame memory arbiter. VGA reads always win; camera writes
// are queued in a small FIFO and drained on cycles without a read.
// Optional statistics counters are built only when FRAME_ARB_STATS_EN
// is defined; otherwise stall_cnt/drop_cnt are tied to zero.
module frame_mem_arb #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    frame_mem_arb_if.slave  arb_bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_RD,
        CMD_WR
    } cmd_state_t;

    cmd_state_t        r_state;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;

    logic [ADDR_W-1:0] r_fifoAddr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifoData [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_overflow;

    logic              r_rdPend;
    logic              r_vgaValid;
    logic [DATA_W-1:0] r_vgaQ;

    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [PTR_W-1:0]  w_wrIdx;
    logic [CNT_W-1:0]  w_countNext;

    // A pop only happens when the head is actually issued as a WR; a flush
    // suppresses the issue so nothing from the discarded contents escapes.
    // During a flush the concurrent write is always kept as the new sole entry.
    assign w_empty     = (r_count == '0);
    assign w_pop       = !arb_bus.vga_req && !w_empty && !arb_bus.cam_flush;
    assign w_push      = arb_bus.cam_wr && (arb_bus.cam_flush || !r_full);
    assign w_drop      = arb_bus.cam_wr && r_full && !arb_bus.cam_flush;
    assign w_wrIdx     = arb_bus.cam_flush ? '0 : r_wrPtr;
    assign w_countNext = r_count + {{(CNT_W-1){1'b0}}, w_push}
                                 - {{(CNT_W-1){1'b0}}, w_pop};

    // Command register: pick RD, WR or IDLE every edge, reads first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CMD_IDLE;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else if (arb_bus.vga_req) begin
            r_state    <= CMD_RD;
            r_memAddr  <= arb_bus.vga_addr;
            r_memWdata <= '0;
        end else if (w_pop) begin
            r_state    <= CMD_WR;
            r_memAddr  <= r_fifoAddr[r_rdPtr];
            r_memWdata <= r_fifoData[r_rdPtr];
        end else begin
            r_state    <= CMD_IDLE;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end
    end

    assign arb_bus.mem_en    = (r_state != CMD_IDLE);
    assign arb_bus.mem_we    = (r_state == CMD_WR);
    assign arb_bus.mem_addr  = r_memAddr;
    assign arb_bus.mem_wdata = r_memWdata;

    // Write FIFO storage; contents need no reset since the count guards them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoAddr[w_wrIdx] <= arb_bus.cam_addr;
            r_fifoData[w_wrIdx] <= arb_bus.cam_data;
        end
    end

    // FIFO pointers, occupancy, registered full flag and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (arb_bus.cam_flush) begin
                r_rdPtr <= '0;
                r_wrPtr <= arb_bus.cam_wr ? PTR_W'(1) : '0;
                r_count <= arb_bus.cam_wr ? CNT_W'(1) : '0;
                r_full  <= arb_bus.cam_wr && (FULL_CNT == CNT_W'(1));
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
                r_count <= w_countNext;
                r_full  <= (w_countNext == FULL_CNT);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign arb_bus.cam_full = r_full;
    assign arb_bus.overflow = r_overflow;

    // Read return pipeline: flag follows RD so the memory's one-cycle data is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdPend   <= 1'b0;
            r_vgaValid <= 1'b0;
            r_vgaQ     <= '0;
        end else begin
            r_rdPend   <= (r_state == CMD_RD);
            r_vgaValid <= r_rdPend;
            if (r_rdPend) begin
                r_vgaQ <= arb_bus.mem_rdata;
            end
        end
    end

    assign arb_bus.vga_q     = r_vgaQ;
    assign arb_bus.vga_valid = r_vgaValid;

`ifdef FRAME_ARB_STATS_EN
    logic [15:0] r_stallCnt;
    logic [15:0] r_dropCnt;

    // Saturating statistics: write-blocked-by-read cycles and dropped writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_dropCnt  <= '0;
        end else if (arb_bus.cam_flush) begin
            r_stallCnt <= '0;
            r_dropCnt  <= '0;
        end else begin
            if (!w_empty && arb_bus.vga_req && (r_stallCnt != 16'hFFFF)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
            if (w_drop && (r_dropCnt != 16'hFFFF)) begin
                r_dropCnt <= r_dropCnt + 16'd1;
            end
        end
    end

    assign arb_bus.stall_cnt = r_stallCnt;
    assign arb_bus.drop_cnt  = r_dropCnt;
`else
    assign arb_bus.stall_cnt = 16'd0;
    assign arb_bus.drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_frame_mem_arb.sv
// Scoreboard bench for frame_mem_arb. The driver steps a queue-based
// reference model each cycle and pushes expected memory commands and
// read returns; a separate monitor pops and compares them.
module tb_frame_mem_arb;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 4;

    typedef struct {
        bit                isWr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } cmd_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } rd_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    cmd_t cmdQ[$];
    rd_t  rdQ[$];
    ent_t fifoQ[$];
    logic [DATA_W-1:0] refMem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] simMem [logic [ADDR_W-1:0]];
    logic        expFull = 1'b0;
    logic        expOverflow = 1'b0;
    logic [15:0] expStall = '0;
    logic [15:0] expDrop = '0;

    frame_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    frame_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .arb_bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] initVal(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 37 + 11;
        return (a == 17'h00010) ? 9'h1A5 : t[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] refRead(input logic [ADDR_W-1:0] a);
        return refMem.exists(a) ? refMem[a] : initVal(a);
    endfunction

    // Environment memory: one-cycle read latency, writes on command.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                simMem[bus.mem_addr] = bus.mem_wdata;
            end else begin
                bus.mem_rdata <= simMem.exists(bus.mem_addr) ? simMem[bus.mem_addr]
                                                             : initVal(bus.mem_addr);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference model: what the arbiter must do at the coming edge.
    task automatic modelStep(input logic req, input logic [ADDR_W-1:0] ra, input logic wr,
                             input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                             input logic fl);
        int   sizeBefore;
        ent_t e;
        cmd_t c;
        rd_t  r;
        sizeBefore = fifoQ.size();
        if (req) begin
            c.isWr = 1'b0; c.addr = ra; c.data = '0; c.cyc = cyc + 1;
            cmdQ.push_back(c);
            r.data = refRead(ra); r.cyc = cyc + 3;
            rdQ.push_back(r);
        end else if (sizeBefore > 0 && !fl) begin
            e = fifoQ.pop_front();
            c.isWr = 1'b1; c.addr = e.addr; c.data = e.data; c.cyc = cyc + 1;
            cmdQ.push_back(c);
            refMem[e.addr] = e.data;
        end
        if (fl) begin
            fifoQ.delete();
            expStall = '0;
            expDrop  = '0;
            if (wr) begin
                e.addr = wa; e.data = wd;
                fifoQ.push_back(e);
            end
        end else begin
            if (sizeBefore > 0 && req && expStall != 16'hFFFF) expStall = expStall + 16'd1;
            if (wr) begin
                if (sizeBefore == DEPTH) begin
                    expOverflow = 1'b1;
                    if (expDrop != 16'hFFFF) expDrop = expDrop + 16'd1;
                end else begin
                    e.addr = wa; e.data = wd;
                    fifoQ.push_back(e);
                end
            end
        end
        expFull = (fifoQ.size() == DEPTH);
    endtask

    task automatic applyStimulus(input logic req, input logic [ADDR_W-1:0] ra, input logic wr,
                                 input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                 input logic fl);
        @(negedge clk);
        bus.vga_req   = req;
        bus.vga_addr  = ra;
        bus.cam_wr    = wr;
        bus.cam_addr  = wa;
        bus.cam_data  = wd;
        bus.cam_flush = fl;
        modelStep(req, ra, wr, wa, wd, fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.vga_req = 1'b0; bus.cam_wr = 1'b0; bus.cam_flush = 1'b0;
        #1;
        checkOutput("rst_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_vga_valid", 32'(bus.vga_valid), 32'd0);
        checkOutput("rst_cam_full", 32'(bus.cam_full), 32'd0);
        checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
        cmdQ.delete(); rdQ.delete(); fifoQ.delete();
        expFull = 1'b0; expOverflow = 1'b0; expStall = '0; expDrop = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares every DUT output against the queued expectations.
    initial begin
        cmd_t c;
        rd_t  r;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (bus.mem_en) begin
                    if (cmdQ.size() == 0) begin
                        checkOutput("mem_cmd_unexpected", 32'd1, 32'd0);
                    end else begin
                        c = cmdQ.pop_front();
                        checkOutput("mem_cmd",
                            {5'd0, bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 9'd0},
                            {5'd0, c.isWr, c.addr, c.data});
                        checkOutput("mem_cmd_cycle", cyc, c.cyc);
                    end
                end else if (cmdQ.size() > 0 && cmdQ[0].cyc <= cyc) begin
                    c = cmdQ.pop_front();
                    checkOutput("mem_cmd_missing", 32'd0, 32'd1);
                end
                if (bus.vga_valid) begin
                    if (rdQ.size() == 0) begin
                        checkOutput("vga_valid_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = rdQ.pop_front();
                        checkOutput("vga_q", 32'(bus.vga_q), 32'(r.data));
                        checkOutput("vga_cycle", cyc, r.cyc);
                    end
                end else if (rdQ.size() > 0 && rdQ[0].cyc <= cyc) begin
                    r = rdQ.pop_front();
                    checkOutput("vga_valid_missing", 32'd0, 32'd1);
                end
                checkOutput("cam_full", 32'(bus.cam_full), 32'(expFull));
                checkOutput("overflow", 32'(bus.overflow), 32'(expOverflow));
`ifdef FRAME_ARB_STATS_EN
                checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(expStall));
                checkOutput("drop_cnt", 32'(bus.drop_cnt), 32'(expDrop));
`else
                checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'd0);
                checkOutput("drop_cnt", 32'(bus.drop_cnt), 32'd0);
`endif
            end
        end
    end

    // Stimulus: directed scenarios then randomized traffic.
    initial begin
        logic req, wr, fl;
        bus.vga_req = 1'b0; bus.vga_addr = '0; bus.cam_wr = 1'b0;
        bus.cam_addr = '0; bus.cam_data = '0; bus.cam_flush = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(5);

        applyStimulus(1'b1, 17'h00010, 1'b0, '0, '0, 1'b0);
        idle(4);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 17'(16 + i), 1'b0, '0, '0, 1'b0);
        idle(5);

        applyStimulus(1'b1, 17'h00040, 1'b1, 17'h00020, 9'h0F0, 1'b0);
        for (int i = 1; i < 6; i++) applyStimulus(1'b1, 17'(64 + i), 1'b0, '0, '0, 1'b0);
        idle(5);

        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 17'(80 + i), (i < 6), 17'(256 + i), 9'(i * 3 + 1), 1'b0);
        idle(8);

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 17'(96 + i), 1'b1, 17'(512 + i), 9'(100 + i), 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 17'h00030, 9'h033, 1'b1);
        idle(5);

        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 17'(112 + i), (i < 3), 17'(768 + i), 9'(i + 7), 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 17'h00301, 9'h055, 1'b0);
        applyStimulus(1'b1, 17'h00011, 1'b0, '0, '0, 1'b0);
        applyStimulus(1'b1, 17'h00012, 1'b0, '0, '0, 1'b0);
        doReset();
        idle(3);
        applyStimulus(1'b1, 17'h00010, 1'b0, '0, '0, 1'b0);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            req = ($urandom_range(0, 99) < 40);
            fl  = ($urandom_range(0, 99) < 3);
            wr  = ($urandom_range(0, 1) == 1);
            if (fl && fifoQ.size() == DEPTH) wr = 1'b0;
            applyStimulus(req, 17'($urandom_range(0, 63)), wr, 17'($urandom_range(0, 63)),
                          9'($urandom), fl);
        end
        idle(12);

        checkOutput("cmd_queue_drained", cmdQ.size(), 32'd0);
        checkOutput("rd_queue_drained", rdQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
